// File: rtl/hw2_pkg.sv
// Shared types and defaults for the HW2 add/multiply arbiter slice.
// Holds the operand width default, the arbiter state encoding and the response ID type.
package hw2_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic rsp_id_t;

endpackage

// File: rtl/hw2_addmul_dp.sv
// Purely combinational (a +/- b) * c datapath, result truncated to 2*WIDTH bits.
// Operands are unsigned; subtraction wraps as two's complement in the wide domain.
module hw2_addmul_dp
  import hw2_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  input  logic               s,
  output logic [2*WIDTH-1:0] d
);

  logic [2*WIDTH-1:0] a_x;
  logic [2*WIDTH-1:0] b_x;
  logic [2*WIDTH-1:0] c_x;
  logic [2*WIDTH-1:0] sum;

  always_comb begin
    a_x = {{WIDTH{1'b0}}, a};
    b_x = {{WIDTH{1'b0}}, b};
    c_x = {{WIDTH{1'b0}}, c};
    sum = s ? (a_x + b_x) : (a_x - b_x);
    d   = sum * c_x;
  end

endmodule

// File: rtl/hw2_addmul_arbiter.sv
// Two-requester round-robin front end time-sharing one (a +/- b) * c datapath.
// Define HW2_ARB_STATS_EN to add saturating per-requester accept counters.
module hw2_addmul_arbiter
  import hw2_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic [WIDTH-1:0]   req0_c,
  input  logic               req0_s,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  input  logic [WIDTH-1:0]   req1_c,
  input  logic               req1_s,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_d,
  output logic               rsp_id,
  output logic               busy
`ifdef HW2_ARB_STATS_EN
  ,
  output logic [15:0]        stat0_cnt,
  output logic [15:0]        stat1_cnt
`endif
);

  state_t             state;
  state_t             state_nxt;
  rsp_id_t            grant_id;
  rsp_id_t            id_q;
  logic               last_served;
  logic               accept;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   c_q;
  logic               s_q;
  logic [2*WIDTH-1:0] dp_d;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_id   = (req0_valid && req1_valid) ? ~last_served : req1_valid;
    accept     = (state == IDLE) && !rst && (req0_valid || req1_valid);
    req0_ready = accept && (grant_id == 1'b0);
    req1_ready = accept && (grant_id == 1'b1);

    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  hw2_addmul_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .a (a_q),
    .b (b_q),
    .c (c_q),
    .s (s_q),
    .d (dp_d)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      last_served <= 1'b1;
      id_q        <= 1'b0;
      // NOTE: the operand registers are plain flops, so they are reset like any other state rather than left to power-up values.
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      s_q         <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_d       <= '0;
      rsp_id      <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);

      if (accept) begin
        last_served <= grant_id;
        id_q        <= grant_id;
        a_q         <= grant_id ? req1_a : req0_a;
        b_q         <= grant_id ? req1_b : req0_b;
        c_q         <= grant_id ? req1_c : req0_c;
        s_q         <= grant_id ? req1_s : req0_s;
      end

      if (state == CALC) begin
        rsp_d     <= dp_d;
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef HW2_ARB_STATS_EN
  // Counters stick at all-ones instead of wrapping back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat0_cnt <= '0;
      stat1_cnt <= '0;
    end else begin
      if (req0_ready && (stat0_cnt != 16'hFFFF)) stat0_cnt <= stat0_cnt + 16'd1;
      if (req1_ready && (stat1_cnt != 16'hFFFF)) stat1_cnt <= stat1_cnt + 16'd1;
    end
  end
`endif

endmodule
